// File: rtl/i2s_tx.sv
// I2S transmitter for the Pmod I2S2 DAC: derives mclk/sck/lrck from one free-running
// counter and shifts out double-buffered 16-bit left/right samples, MSB first.
module i2s_tx #(
  parameter int unsigned MCLK_LOG2 = 2,
  parameter int unsigned SCK_LOG2  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_tick
);

  localparam int unsigned CntW = SCK_LOG2 + 5;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt;
  logic [15:0]     left_hold;
  logic [15:0]     right_hold;
  logic            sdin_r;
  logic            tick_r;

  logic            slot_end;
  logic            frame_end;
  logic [4:0]      k_next;
  logic [3:0]      bit_idx;
  logic            use_left;
  logic            next_bit;

  always_comb begin
    slot_end  = &cnt[SCK_LOG2-1:0];
    frame_end = &cnt;
    k_next    = cnt[CntW-1:SCK_LOG2] + 5'd1;
    // (16 - k) mod 16 selects left[16-k] for k=1..16 and right[32-k] for k=17..31,0.
    bit_idx   = 4'd0 - k_next[3:0];
    use_left  = (k_next != 5'd0) && (k_next <= 5'd16);
    next_bit  = use_left ? left_hold[bit_idx] : right_hold[bit_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_hold  <= '0;
      right_hold <= '0;
      tick_r     <= 1'b0;
    end else begin
      tick_r <= frame_end;
      if (frame_end) begin
        left_hold  <= en ? audio_left  : 16'h0000;
        right_hold <= en ? audio_right : 16'h0000;
      end
    end
  end

  // Data moves only on sck falling edges; slot 0 reads right_hold before it reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdin_r <= 1'b0;
    end else if (slot_end) begin
      sdin_r <= next_bit;
    end
  end

  assign audio_mclk  = cnt[MCLK_LOG2-1];
  assign audio_sck   = cnt[SCK_LOG2-1];
  assign audio_lrck  = cnt[CntW-1];
  assign audio_sdin  = sdin_r;
  assign sample_tick = tick_r;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a cycle counter predicts clock pins and latch timing; a scoreboard of
// expected {left,right} words is checked against an I2S receiver on the serial pins.
module tb_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        sample_tick;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tc;
  logic [31:0] exp_q[$];
  logic [31:0] sr;
  logic        prev_l;

  i2s_tx #(
    .MCLK_LOG2(2),
    .SCK_LOG2 (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin),
    .sample_tick(sample_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference cycle count since reset; expected word for the next frame queued at frame end.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc <= 0;
      exp_q.delete();
      exp_q.push_back(32'h0);
    end else begin
      if (tc[8:0] == 9'h1ff) exp_q.push_back(en ? {audio_left, audio_right} : 32'h0);
      tc <= tc + 1;
    end
  end

  // I2S receiver: a frame's word is complete at the first sck rise after lrck returns low.
  always @(posedge audio_sck or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      prev_l <= 1'b0;
    end else begin
      if (prev_l && !audio_lrck) begin
        check_eq("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_eq("word", {sr[30:0], audio_sdin}, exp_q.pop_front());
      end
      sr     <= {sr[30:0], audio_sdin};
      prev_l <= audio_lrck;
    end
  end

  always @(negedge clk) begin
    check_eq("mclk", audio_mclk, tc[1]);
    check_eq("sck", audio_sck, tc[3]);
    check_eq("lrck", audio_lrck, tc[8]);
    check_eq("sample_tick", sample_tick, (tc != 0) && (tc[8:0] == 9'h000));
  end

  task automatic wait_tc(input int unsigned target);
    int unsigned n = 0;
    while (tc != target && n < 100000) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_tc", tc, target);
  endtask

  initial begin
    en          = 1'b1;
    audio_left  = 16'hA55A;
    audio_right = 16'h3C0F;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    repeat (20) @(posedge clk);
    #1 check_eq("reset_outputs",
                {audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 512; i++) begin
      @(posedge clk);
      #1 check_eq("sdin_first_frame", audio_sdin, 1'b0);
    end

    // Mid-frame input changes only reach the following frame.
    wait_tc(2 * 512 + 5 * 16);
    audio_left = 16'hFFFF;
    wait_tc(2 * 512 + 20 * 16);
    audio_left = 16'h0001;

    // Mute and resume.
    wait_tc(3 * 512 + 10 * 16);
    audio_left  = 16'hDFF0;
    audio_right = 16'hD000;
    wait_tc(4 * 512 + 10 * 16);
    en = 1'b0;
    wait_tc(5 * 512 + 3 * 16);
    en = 1'b1;
    wait_tc(6 * 512 + 8 * 16);
    audio_left  = 16'h1234;
    audio_right = 16'h8765;

    // Asynchronous reset mid-slot while mclk, sck and sdin are all high.
    wait_tc(7 * 512 + 12 * 16 + 10);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset",
                {audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 512; i++) begin
      @(posedge clk);
      #1 check_eq("sdin_after_reset", audio_sdin, 1'b0);
    end
    wait_tc(2 * 512 + 8 * 16);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
